// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-side signals of the round-robin write arbiter
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_full;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-locked round-robin arbiter sharing one FIFO write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]  owner, owner_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [ID_W-1:0]  pick;
  logic             pick_ok;
  logic             beat;
  int               idx;

  // Circular search starting just after the last owner, so it ends up lowest priority.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_ok && bus.req_valid[idx]) begin
        pick_ok = 1'b1;
        pick    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    rr_ptr_nxt       = rr_ptr;
    owner_nxt        = owner;
    beat_cnt_nxt     = beat_cnt;
    beat             = 1'b0;
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = '0;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          owner_nxt    = pick;
          beat_cnt_nxt = '0;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        // rst gating keeps an aborted burst from writing in the reset cycle itself.
        bus.req_ready[owner] = !bus.fifo_full && !rst;
        beat                 = bus.req_valid[owner] && !bus.fifo_full && !rst;
        bus.fifo_wr_en       = beat;
        if (beat) begin
          bus.fifo_wr_data = bus.req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
          beat_cnt_nxt     = beat_cnt + CNT_W'(1);
          if (bus.req_last[owner] || beat_cnt == CNT_W'(MAX_BURST - 1)) begin
            rr_ptr_nxt = owner;
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  assign bus.grant_id = owner;
  assign bus.busy     = (state == GRANT) && !rst;
endmodule
